load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access initiator between the multicycle datapath control and the 32-word data memory.
- Takes a byte address, data and funct3 from the datapath. Drives word-addressed read/write requests to the memory.
- Handles byte/halfword loads with sign or zero extension. Handles sub-word stores by read-modify-write.
- Returns the load result with a one-cycle done pulse, plus an error flag for misaligned, out-of-range or illegal requests.

Parameters:
- ADDR_W, 5: word-index width of data memory (2^ADDR_W words).
- DATA_W, 32: data width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request strobe. Sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load. Sampled with start.
- funct3  in  3  RV32I width code. Sampled with start.
- addr  in  32  byte address (ALU result). Sampled with start.
- wdata  in  32  store data (rs2). Sampled with start.
- mem_addr  out  ADDR_W  word index = latched addr[ADDR_W+1:2].
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  memory read data; valid the cycle after mem_re.
- load_data  out  32  extended load result. Held until the next load completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done. 1 = request rejected.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state <= IDLE.
  - load_data, done and err <= 0. Request registers cleared.
  - Takes priority over everything, including mid-operation: a pending store is never written.
- Memory outputs are combinational from state and request registers. mem_re=1 only in ISSUE; mem_we=1 only in WRITE. mem_addr/mem_wdata are 0 when both requests are low.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], offset = addr[1:0].
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other value is an error.
- Error checks, evaluated in IDLE on start:
  - illegal funct3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_W+2] != 0.
  - Any error -> state ERR. No memory request is issued.
- States:
  - IDLE: start=1 -> latch inputs, then go to ERR / WRITE (sw) / ISSUE (all others). start=0 -> stay.
  - ISSUE: mem_re=1 -> CAPTURE.
  - CAPTURE: mem_rdata valid.
    - Load: load_data <= extracted and extended lane; done <= 1; -> IDLE.
    - Store: merge register <= mem_rdata with the addressed byte/half replaced by wdata[7:0] or wdata[15:0]; -> WRITE.
  - WRITE: mem_we=1. mem_wdata = merge register (sb/sh) or wdata (sw). done <= 1; -> IDLE.
  - ERR: done <= 1, err <= 1; -> IDLE.
- done and err are cleared on every cycle they are not set.
- Latency, with start in cycle 0 and done high in cycle N:
  - load: N=3;
  - sw: N=2;
  - sb/sh: N=4;
  - error: N=2.
- start while busy is ignored (no queueing). A new start is accepted in the same cycle done is high, because state is IDLE then.
- load_data is unchanged by stores and by errors.
- The back-to-back write-then-read hazard is owned by the memory's registered timing. The FSM always spends at least one IDLE cycle between requests.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum (IDLE, ISSUE, CAPTURE, WRITE, ERR), 3-bit;
  - the DATA_W localparam.
- One combinational sub-module, lsu_lane_unit:
  - lane extraction with sign/zero extension;
  - store merge.
  - Inputs: word, offset, funct3, wdata. Outputs: load value, merged word.
- The FSM and registers stay in load_store_unit.

Test Plan:
1. Word 3=0x876543F1; lb addr 0x0C -> mem_re in cycle 1 with mem_addr=3; done cycle 3, load_data=0xFFFFFFF1, err=0.
2. Same word: lbu 0x0D -> 0x00000043; lh 0x0E -> 0xFFFF8765; lhu 0x0E -> 0x00008765; lw 0x0C -> 0x876543F1.
3. sb wdata=0x123456AA addr 0x0D, word 3=0x876543F1 -> ISSUE cycle 1, mem_we cycle 3 with mem_wdata=0x8765AAF1, done cycle 4.
4. sw 0xDEADBEEF addr 0x7C -> mem_we cycle 1, mem_addr=31, mem_re never high, done cycle 2.
5. lw 0x0E, sh 0x0F, lw 0x80, funct3=011 -> each: done+err in cycle 2, mem_re=mem_we=0 throughout, load_data unchanged.
6. sh 0xBEEF to 0x06; rst_n=0 during CAPTURE -> next cycle IDLE, mem_we never asserted, done=0. start pulsed during ISSUE of a later load is ignored (one done only).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// funct3 width codes, FSM state encoding and the supported data width.
package lsu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      ERR     = 3'd4
   } state_t;

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane logic: extracts and extends a sub-word load, and merges sub-word store data.
// Purely combinational; little-endian lanes selected by the byte offset.
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        offset,
   input  logic [2:0]        funct3,
   input  logic [15:0]       wdata,
   output logic [DATA_W-1:0] load_val,
   output logic [DATA_W-1:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = word[{offset, 3'b000} +: 8];
      half_v   = word[{offset[1], 4'b0000} +: 16];
      load_val = word;
      merged   = word;
      case (funct3)
         F3_B:  load_val = {{24{byte_v[7]}}, byte_v};
         F3_BU: load_val = {24'd0, byte_v};
         F3_H:  load_val = {{16{half_v[15]}}, half_v};
         F3_HU: load_val = {16'd0, half_v};
         default: load_val = word;
      endcase
      // Only sb/sh reach the merge path; other codes pass the word through.
      if (funct3 == F3_B)
         merged[{offset, 3'b000} +: 8] = wdata[7:0];
      else if (funct3 == F3_H)
         merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: validates a request, issues word reads/writes, extends loads, RMWs sub-word stores.
// Latency start->done: load 3, sw 2, sb/sh 4, error 2; start is ignored while busy.
module load_store_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = lsu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] load_data,
   output logic              done,
   output logic              err,
   output logic              busy
);
   import lsu_pkg::*;

   state_t              state, state_nx;
   logic                req_store;
   logic [2:0]          req_f3;
   logic [ADDR_W-1:0]   req_idx;
   logic [1:0]          req_off;
   logic [DATA_W-1:0]   req_wdata;
   logic [DATA_W-1:0]   merge_q;
   logic                req_bad;
   logic [DATA_W-1:0]   lane_load;
   logic [DATA_W-1:0]   lane_merged;

   lsu_lane_unit u_lane (
      .word     (mem_rdata),
      .offset   (req_off),
      .funct3   (req_f3),
      .wdata    (req_wdata[15:0]),
      .load_val (lane_load),
      .merged   (lane_merged)
   );

   // Request validation on the raw inputs, so a rejected request never touches memory.
   always_comb begin
      case (funct3)
         F3_B, F3_H, F3_W: req_bad = 1'b0;
         F3_BU, F3_HU:     req_bad = is_store;
         default:          req_bad = 1'b1;
      endcase
      if (funct3[1:0] == 2'b01 && addr[0])
         req_bad = 1'b1;
      if (funct3 == F3_W && addr[1:0] != 2'b00)
         req_bad = 1'b1;
      if (addr[31:ADDR_W+2] != '0)
         req_bad = 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (req_bad)
                  state_nx = ERR;
               else if (is_store && funct3 == F3_W)
                  state_nx = WRITE;
               else
                  state_nx = ISSUE;
            end
         end
         ISSUE:   state_nx = CAPTURE;
         CAPTURE: state_nx = req_store ? WRITE : IDLE;
         WRITE:   state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_re    = (state == ISSUE);
      mem_we    = (state == WRITE);
      mem_addr  = (mem_re || mem_we) ? req_idx : '0;
      mem_wdata = '0;
      if (mem_we)
         mem_wdata = (req_f3 == F3_W) ? req_wdata : merge_q;
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_store <= 1'b0;
         req_f3    <= '0;
         req_idx   <= '0;
         req_off   <= '0;
         req_wdata <= '0;
         merge_q   <= '0;
         load_data <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         err   <= 1'b0;
         if (state == IDLE && start) begin
            req_store <= is_store;
            req_f3    <= funct3;
            req_idx   <= addr[ADDR_W+1:2];
            req_off   <= addr[1:0];
            req_wdata <= wdata;
         end
         case (state)
            CAPTURE: begin
               if (req_store) begin
                  merge_q <= lane_merged;
               end else begin
                  load_data <= lane_load;
                  done      <= 1'b1;
               end
            end
            WRITE: done <= 1'b1;
            ERR: begin
               done <= 1'b1;
               err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
